// File: rtl/uart_pkg.sv
// Shared definitions for the UART echo buffer: parity modes, FSM state encoding and
// baud-timing helpers.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  // Used by both the RX and TX FSMs; StParity is skipped when parity is off.
  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  function automatic int unsigned calc_bps_cnt(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

  function automatic int unsigned calc_cnt_width(input int unsigned bps_cnt);
    return (bps_cnt < 2) ? 1 : $clog2(bps_cnt);
  endfunction

  // Data is zero-extended, so XOR over all 8 bits equals XOR over the frame's data bits.
  function automatic logic parity_bit(input logic [7:0] data, input int unsigned mode);
    return (mode == PAR_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with registered level/full/empty; a push while full is accepted only
// when a pop happens in the same cycle.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]  level_q, level_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  assign do_pop  = pop & ~empty_q;
  assign do_push = push & (~full_q | do_pop);

  always_comb begin
    level_d = level_q;
    unique case ({do_push, do_pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      level_q <= level_d;
      full_q  <= (level_d == LvlW'(DEPTH));
      empty_q <= (level_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

  assign rdata = mem[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;
  assign level = level_q;

endmodule

// File: rtl/uart_echo_buffer.sv
// UART loopback: receives frames, buffers good bytes in a FIFO and re-transmits them
// back-to-back, with pause control, FIFO level and sticky error flags.
module uart_echo_buffer
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned UART_BPS   = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic                          uart_rxd,
  output logic                          uart_txd,
  input  logic                          tx_pause,
  input  logic                          err_clr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          parity_err,
  output logic                          frame_err
);

  localparam int unsigned BpsCnt  = calc_bps_cnt(CLK_FREQ, UART_BPS);
  localparam int unsigned CntW    = calc_cnt_width(BpsCnt);
  localparam int unsigned HalfCnt = BpsCnt / 2;

  logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0] fifo_rdata;

  // ---------------- RX ----------------
  // [1:0] synchroniser, [2] previous synchronised value for edge detection
  logic [2:0] rx_sync_q;
  logic       rx_bit, rx_fall;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) rx_sync_q <= '1;
    else         rx_sync_q <= {rx_sync_q[1:0], uart_rxd};
  end

  assign rx_bit  = rx_sync_q[1];
  assign rx_fall = rx_sync_q[2] & ~rx_sync_q[1];

  uart_state_e          rx_state_q, rx_state_d;
  logic [CntW-1:0]      rx_cnt_q, rx_cnt_d;
  logic [2:0]           rx_idx_q, rx_idx_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_par_bad_q, rx_par_bad_d;
  logic                 rx_done, rx_stop_ok, rx_last;
  logic [7:0]           rx_byte;

  assign rx_last = (rx_cnt_q == CntW'(BpsCnt - 1));
  assign rx_byte = 8'(rx_shift_q);

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q + CntW'(1);
    rx_idx_d     = rx_idx_q;
    rx_shift_d   = rx_shift_q;
    rx_par_bad_d = rx_par_bad_q;
    rx_done      = 1'b0;
    rx_stop_ok   = 1'b0;
    unique case (rx_state_q)
      StIdle: begin
        rx_cnt_d = '0;
        if (rx_fall) rx_state_d = StStart;
      end
      StStart: begin
        if (rx_cnt_q == CntW'(HalfCnt)) begin
          rx_cnt_d     = '0;
          rx_idx_d     = '0;
          rx_par_bad_d = 1'b0;
          rx_state_d   = rx_bit ? StIdle : StData;
        end
      end
      StData: begin
        if (rx_last) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_bit, rx_shift_q[DATA_BITS-1:1]};
          rx_idx_d   = rx_idx_q + 3'd1;
          if (rx_idx_q == 3'(DATA_BITS - 1)) begin
            rx_state_d = (PARITY != PAR_NONE) ? StParity : StStop;
          end
        end
      end
      StParity: begin
        if (rx_last) begin
          rx_cnt_d     = '0;
          rx_par_bad_d = (rx_bit != parity_bit(rx_byte, PARITY));
          rx_state_d   = StStop;
        end
      end
      StStop: begin
        if (rx_last) begin
          rx_cnt_d   = '0;
          rx_done    = 1'b1;
          rx_stop_ok = rx_bit;
          rx_state_d = StIdle;
        end
      end
      default: rx_state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rx_state_q   <= StIdle;
      rx_cnt_q     <= '0;
      rx_idx_q     <= '0;
      rx_shift_q   <= '0;
      rx_par_bad_q <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_idx_q     <= rx_idx_d;
      rx_shift_q   <= rx_shift_d;
      rx_par_bad_q <= rx_par_bad_d;
    end
  end

  // Priority on rx_done: framing error, then parity error, then overflow.
  logic rx_good, set_frame, set_par, set_ovf;
  assign rx_good   = rx_done & rx_stop_ok & ~rx_par_bad_q;
  assign set_frame = rx_done & ~rx_stop_ok;
  assign set_par   = rx_done & rx_stop_ok & rx_par_bad_q;
  assign set_ovf   = rx_good & fifo_full & ~fifo_pop;
  assign fifo_push = rx_good & (~fifo_full | fifo_pop);

  logic ovf_q, perr_q, ferr_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      ovf_q  <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      ovf_q  <= set_ovf   | (ovf_q  & ~err_clr);
      perr_q <= set_par   | (perr_q & ~err_clr);
      ferr_q <= set_frame | (ferr_q & ~err_clr);
    end
  end

  assign overflow   = ovf_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .push  (fifo_push),
    .wdata (rx_byte),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // ---------------- TX ----------------
  uart_state_e          tx_state_q, tx_state_d;
  logic [CntW-1:0]      tx_cnt_q, tx_cnt_d;
  logic [2:0]           tx_idx_q, tx_idx_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic                 txd_q, txd_d;
  logic                 tx_load, tx_last, tx_can_start;

  assign tx_last      = (tx_cnt_q == CntW'(BpsCnt - 1));
  assign tx_can_start = ~fifo_empty & ~tx_pause;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + CntW'(1);
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    txd_d      = txd_q;
    tx_load    = 1'b0;
    unique case (tx_state_q)
      StIdle: begin
        tx_cnt_d = '0;
        txd_d    = 1'b1;
        tx_load  = tx_can_start;
      end
      StStart: begin
        if (tx_last) begin
          tx_cnt_d   = '0;
          tx_idx_d   = '0;
          txd_d      = tx_shift_q[0];
          tx_state_d = StData;
        end
      end
      StData: begin
        if (tx_last) begin
          tx_cnt_d = '0;
          if (tx_idx_q == 3'(DATA_BITS - 1)) begin
            if (PARITY != PAR_NONE) begin
              txd_d      = tx_par_q;
              tx_state_d = StParity;
            end else begin
              txd_d      = 1'b1;
              tx_state_d = StStop;
            end
          end else begin
            tx_idx_d   = tx_idx_q + 3'd1;
            tx_shift_d = tx_shift_q >> 1;
            txd_d      = tx_shift_q[1];
          end
        end
      end
      StParity: begin
        if (tx_last) begin
          tx_cnt_d   = '0;
          txd_d      = 1'b1;
          tx_state_d = StStop;
        end
      end
      StStop: begin
        // Chain straight into the next start bit so queued bytes leave back-to-back.
        if (tx_last) begin
          tx_cnt_d = '0;
          tx_load  = tx_can_start;
          if (!tx_can_start) tx_state_d = StIdle;
        end
      end
      default: tx_state_d = StIdle;
    endcase

    if (tx_load) begin
      tx_state_d = StStart;
      tx_cnt_d   = '0;
      txd_d      = 1'b0;
      tx_shift_d = fifo_rdata[DATA_BITS-1:0];
      tx_par_d   = parity_bit(fifo_rdata, PARITY);
    end
  end

  assign fifo_pop = tx_load;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      tx_state_q <= StIdle;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      txd_q      <= txd_d;
    end
  end

  assign uart_txd = txd_q;

endmodule

// File: tb/tb_uart_echo_buffer.sv
// Scoreboard bench for uart_echo_buffer: three instances (8N1, 8E1, 5O1) at 10 clocks/bit.
module tb_uart_echo_buffer;

  localparam int BPS = 10;

  logic       clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       rxd   [3];
  logic       pause [3];
  logic       eclr  [3];
  logic       txd   [3];
  logic [4:0] lvl   [3];
  logic       ovf   [3];
  logic       perr  [3];
  logic       ferr  [3];

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  logic [7:0] exp0[$], exp1[$], exp2[$];
  int         starts0[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_echo_buffer #(
    .CLK_FREQ(1000000), .UART_BPS(100000), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(16)
  ) u_dut0 (
    .sys_clk(clk), .sys_rst(sys_rst), .uart_rxd(rxd[0]), .uart_txd(txd[0]),
    .tx_pause(pause[0]), .err_clr(eclr[0]), .fifo_level(lvl[0]), .overflow(ovf[0]),
    .parity_err(perr[0]), .frame_err(ferr[0])
  );

  uart_echo_buffer #(
    .CLK_FREQ(1000000), .UART_BPS(100000), .DATA_BITS(8), .PARITY(2), .FIFO_DEPTH(16)
  ) u_dut1 (
    .sys_clk(clk), .sys_rst(sys_rst), .uart_rxd(rxd[1]), .uart_txd(txd[1]),
    .tx_pause(pause[1]), .err_clr(eclr[1]), .fifo_level(lvl[1]), .overflow(ovf[1]),
    .parity_err(perr[1]), .frame_err(ferr[1])
  );

  uart_echo_buffer #(
    .CLK_FREQ(1000000), .UART_BPS(100000), .DATA_BITS(5), .PARITY(1), .FIFO_DEPTH(16)
  ) u_dut2 (
    .sys_clk(clk), .sys_rst(sys_rst), .uart_rxd(rxd[2]), .uart_txd(txd[2]),
    .tx_pause(pause[2]), .err_clr(eclr[2]), .fifo_level(lvl[2]), .overflow(ovf[2]),
    .parity_err(perr[2]), .frame_err(ferr[2])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic exp_par(input logic [7:0] d, input int par);
    return (par == 1) ? ~(^d) : (^d);
  endfunction

  function automatic int qsize(input int idx);
    case (idx)
      0:       return exp0.size();
      1:       return exp1.size();
      default: return exp2.size();
    endcase
  endfunction

  task automatic qpush(input int idx, input logic [7:0] d);
    case (idx)
      0:       exp0.push_back(d);
      1:       exp1.push_back(d);
      default: exp2.push_back(d);
    endcase
  endtask

  task automatic qpop(input int idx, output logic [7:0] d);
    case (idx)
      0:       d = exp0.pop_front();
      1:       d = exp1.pop_front();
      default: d = exp2.pop_front();
    endcase
  endtask

  // Drive one frame on rxd[idx]; each bit is held BPS clocks, starting just after an edge.
  task automatic send(input int idx, input int nbits, input int par, input logic [7:0] d,
                      input logic flip_par, input logic stop_val, input logic echo);
    logic [7:0] m;
    m = d & 8'((1 << nbits) - 1);
    @(posedge clk); #1;
    if (echo) qpush(idx, m);
    rxd[idx] = 1'b0;
    repeat (BPS) @(posedge clk); #1;
    for (int i = 0; i < nbits; i++) begin
      rxd[idx] = m[i];
      repeat (BPS) @(posedge clk); #1;
    end
    if (par != 0) begin
      rxd[idx] = exp_par(m, par) ^ flip_par;
      repeat (BPS) @(posedge clk); #1;
    end
    rxd[idx] = stop_val;
    repeat (BPS) @(posedge clk); #1;
    rxd[idx] = 1'b1;
  endtask

  // Decode frames on txd[idx] and compare each against the scoreboard head.
  task automatic monitor(input int idx, input int nbits, input int par);
    logic [11:0] fb;
    logic [7:0]  d, e;
    logic        stable, aborted;
    int          total, s;
    total = 2 + nbits + ((par != 0) ? 1 : 0);
    forever begin
      @(negedge clk);
      if (!sys_rst && txd[idx] === 1'b0) begin
        s = cyc; stable = 1'b1; aborted = 1'b0; fb = '0; d = '0;
        for (int b = 0; b < total && !aborted; b++) begin
          for (int j = 0; j < BPS && !aborted; j++) begin
            if (b != 0 || j != 0) @(negedge clk);
            if (sys_rst) aborted = 1'b1;
            else if (j == 0) fb[b] = txd[idx];
            else if (txd[idx] !== fb[b]) stable = 1'b0;
          end
        end
        if (!aborted) begin
          for (int i = 0; i < nbits; i++) d[i] = fb[i + 1];
          if (idx == 0) starts0.push_back(s);
          if (qsize(idx) == 0) begin
            n_total++;
            $display("FAIL unexpected_frame[%0d]: got %0h, expected no frame", idx, d);
          end else begin
            qpop(idx, e);
            chk($sformatf("echo_data[%0d]", idx), 32'(d), 32'(e));
            if (par != 0) chk($sformatf("echo_parity[%0d]", idx), 32'(fb[nbits + 1]),
                              32'(exp_par(e, par)));
            chk($sformatf("echo_stop[%0d]", idx), 32'(fb[total - 1]), 32'd1);
            chk($sformatf("bit_width[%0d]", idx), 32'(stable), 32'd1);
          end
        end
      end
    end
  endtask

  task automatic wait_drain(input int idx, input int limit);
    int n;
    n = 0;
    while (qsize(idx) != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("drain[%0d]", idx), 32'(qsize(idx)), 32'd0);
    repeat (20) @(negedge clk);
  endtask

  task automatic pulse_clr(input int idx);
    @(posedge clk); #1;
    eclr[idx] = 1'b1;
    @(posedge clk); #1;
    eclr[idx] = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0, n;
    for (int i = 0; i < 3; i++) begin
      rxd[i] = 1'b1; pause[i] = 1'b0; eclr[i] = 1'b0;
    end
    fork
      monitor(0, 8, 0);
      monitor(1, 8, 2);
      monitor(2, 5, 1);
    join_none
    repeat (3) @(posedge clk); #1;
    sys_rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_txd[%0d]", i), 32'(txd[i]), 32'd1);
      chk($sformatf("reset_level[%0d]", i), 32'(lvl[i]), 32'd0);
      chk($sformatf("reset_flags[%0d]", i), 32'({ovf[i], perr[i], ferr[i]}), 32'd0);
    end

    // 1: 8N1 echo of 0xA5 with exact latency and level 0->1->0
    starts0.delete();
    fork send(0, 8, 0, 8'hA5, 1'b0, 1'b1, 1'b1); join_none
    @(posedge clk); #1;
    t0 = cyc;
    while (cyc < t0 + 99) @(negedge clk);
    chk("level_after_push", 32'(lvl[0]), 32'd1);
    @(negedge clk);
    chk("level_after_pop", 32'(lvl[0]), 32'd0);
    chk("txd_start_bit", 32'(txd[0]), 32'd0);
    wait_drain(0, 300);
    chk("start_latency", (starts0.size() > 0) ? 32'(starts0[0]) : 32'hFFFF, 32'(t0 + 100));

    // 2: even parity, good then bad parity on 0x3C
    send(1, 8, 2, 8'h3C, 1'b0, 1'b1, 1'b1);
    wait_drain(1, 300);
    send(1, 8, 2, 8'h3C, 1'b1, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    chk("parity_err_set", 32'(perr[1]), 32'd1);
    chk("parity_drop_level", 32'(lvl[1]), 32'd0);

    // 3: paused overflow, then back-to-back drain of 16 bytes
    pause[0] = 1'b1;
    for (int i = 0; i < 17; i++) send(0, 8, 0, 8'(i), 1'b0, 1'b1, (i < 16));
    repeat (5) @(negedge clk);
    chk("full_level", 32'(lvl[0]), 32'd16);
    chk("overflow_set", 32'(ovf[0]), 32'd1);
    starts0.delete();
    pause[0] = 1'b0;
    wait_drain(0, 2500);
    chk("burst_frames", 32'(starts0.size()), 32'd16);
    n = 0;
    for (int i = 1; i < starts0.size(); i++) if (starts0[i] - starts0[i - 1] != 100) n++;
    chk("burst_back_to_back", 32'(n), 32'd0);

    // 4: framing error; err_clr coinciding with a parity error
    send(0, 8, 0, 8'h55, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("frame_err_set", 32'(ferr[0]), 32'd1);
    chk("frame_drop_level", 32'(lvl[0]), 32'd0);
    pulse_clr(1);
    @(negedge clk);
    chk("parity_err_cleared", 32'(perr[1]), 32'd0);
    fork send(1, 8, 2, 8'h3C, 1'b1, 1'b1, 1'b0); join_none
    @(posedge clk); #1;
    t0 = cyc;
    while (cyc < t0 + 108) begin @(posedge clk); #1; end
    eclr[1] = 1'b1;
    @(posedge clk); #1;
    eclr[1] = 1'b0;
    @(negedge clk);
    chk("set_beats_clear", 32'(perr[1]), 32'd1);
    repeat (20) @(negedge clk);

    // 5: glitch rejection, then reset mid-TX-frame
    pulse_clr(0);
    @(negedge clk);
    chk("flags_cleared", 32'({ovf[0], perr[0], ferr[0]}), 32'd0);
    @(posedge clk); #1;
    rxd[0] = 1'b0;
    repeat (3) @(posedge clk); #1;
    rxd[0] = 1'b1;
    repeat (150) @(negedge clk);
    chk("glitch_flags", 32'({ovf[0], perr[0], ferr[0]}), 32'd0);
    chk("glitch_level", 32'(lvl[0]), 32'd0);
    pause[0] = 1'b1;
    send(0, 8, 0, 8'h11, 1'b0, 1'b1, 1'b0);
    send(0, 8, 0, 8'h22, 1'b0, 1'b1, 1'b0);
    pause[0] = 1'b0;
    n = 0;
    while (txd[0] !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    chk("tx_started", 32'(txd[0]), 32'd0);
    repeat (30) @(negedge clk);
    chk("level_mid_frame", 32'(lvl[0]), 32'd1);
    @(posedge clk); #1;
    sys_rst = 1'b1;
    @(posedge clk); #1;
    sys_rst = 1'b0;
    @(negedge clk);
    chk("rst_txd", 32'(txd[0]), 32'd1);
    chk("rst_level", 32'(lvl[0]), 32'd0);
    repeat (300) @(negedge clk);

    // 6: 5 data bits, odd parity, 0x1F
    send(2, 5, 1, 8'h1F, 1'b0, 1'b1, 1'b1);
    wait_drain(2, 300);
    chk("o1_flags", 32'({ovf[2], perr[2], ferr[2]}), 32'd0);

    repeat (50) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
